ft_cmd_parser: RTL and testbench

//  Command decoder downstream of the synchronous FT245 interface: pops host bytes from the RX FIFO read side.

---
 rtl/ft_cmd_parser.sv | 189 ++++++++++++++++++
 tb/tb_ft_cmd_parser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_cmd_parser.sv
// FT245 command decoder: turns 5-byte host frames from the RX FIFO into register
// writes/reads and pushes 4-byte read responses into the TX FIFO. Optional macro: CMD_TIMEOUT_EN.
module ft_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  RESP_BYTE = 8'h5A,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_rdata,
  input  logic        rx_rempty,
  output logic        rx_rinc,
  output logic [7:0]  tx_wdata,
  input  logic        tx_wfull,
  output logic        tx_winc,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic [7:0]  err_count,
  output logic [3:0]  fsm_state
);

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [3:0] {
    S_HUNT    = 4'd0,
    S_CMD     = 4'd1,
    S_ADDR    = 4'd2,
    S_DHI     = 4'd3,
    S_DLO     = 4'd4,
    S_EXEC_WR = 4'd5,
    S_EXEC_RD = 4'd6,
    S_RD_WAIT = 4'd7,
    S_RESP0   = 4'd8,
    S_RESP1   = 4'd9,
    S_RESP2   = 4'd10,
    S_RESP3   = 4'd11
  } state_t;

  state_t      state;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [15:0] rdata_q;
  logic        rx_phase;
  logic        tx_phase;
  logic        timeout_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Handshakes: a byte moves on a clock edge where rx_rinc=1 (only when rx_rempty=0),
  // and a TX byte moves on an edge where tx_winc=1 (only when tx_wfull=0); no other transfer exists.
  always_comb begin
    rx_phase = (state == S_HUNT) || (state == S_CMD) || (state == S_ADDR) ||
               (state == S_DHI)  || (state == S_DLO);
    tx_phase = (state == S_RESP0) || (state == S_RESP1) ||
               (state == S_RESP2) || (state == S_RESP3);
  end

  assign rx_rinc   = rx_phase & ~rx_rempty;
  assign tx_winc   = tx_phase & ~tx_wfull;
  assign fsm_state = state;

  // A TIMEOUT below 2 leaves no room for an idle cycle; such builds elaborate nothing here.
  if (TIMEOUT < 2) begin : g_timeout_too_small
  end

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            frame_open;

  assign frame_open  = (state == S_CMD) || (state == S_ADDR) ||
                       (state == S_DHI) || (state == S_DLO);
  assign timeout_hit = frame_open && !rx_rinc && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst || !frame_open || rx_rinc || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HUNT;
      tx_wdata  <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 16'h0000;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err_count <= 8'h00;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      dhi_q     <= 8'h00;
      rdata_q   <= 16'h0000;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (timeout_hit) begin
        err_count <= sat_inc(err_count);
        state     <= S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            if (rx_rinc && (rx_rdata == SYNC_BYTE)) state <= S_CMD;
          end
          S_CMD: begin
            if (rx_rinc) begin
              cmd_q <= rx_rdata;
              state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (rx_rinc) begin
              addr_q <= rx_rdata;
              state  <= S_DHI;
            end
          end
          S_DHI: begin
            if (rx_rinc) begin
              dhi_q <= rx_rdata;
              state <= S_DLO;
            end
          end
          S_DLO: begin
            if (rx_rinc) begin
              if (cmd_q == CMD_WR) begin
                reg_we    <= 1'b1;
                reg_addr  <= addr_q;
                reg_wdata <= {dhi_q, rx_rdata};
                state     <= S_EXEC_WR;
              end else if (cmd_q == CMD_RD) begin
                reg_re   <= 1'b1;
                reg_addr <= addr_q;
                state    <= S_EXEC_RD;
              end else begin
                err_count <= sat_inc(err_count);
                state     <= S_HUNT;
              end
            end
          end
          S_EXEC_WR: state <= S_HUNT;
          S_EXEC_RD: state <= S_RD_WAIT;
          S_RD_WAIT: begin
            // reg_rdata is valid in the cycle after the read strobe.
            rdata_q  <= reg_rdata;
            tx_wdata <= RESP_BYTE;
            state    <= S_RESP0;
          end
          S_RESP0: begin
            if (tx_winc) begin
              tx_wdata <= reg_addr;
              state    <= S_RESP1;
            end
          end
          S_RESP1: begin
            if (tx_winc) begin
              tx_wdata <= rdata_q[15:8];
              state    <= S_RESP2;
            end
          end
          S_RESP2: begin
            if (tx_winc) begin
              tx_wdata <= rdata_q[7:0];
              state    <= S_RESP3;
            end
          end
          S_RESP3: begin
            if (tx_winc) state <= S_HUNT;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ft_cmd_parser.sv
// Directed bench for ft_cmd_parser: RX FIFO model, register-read responder,
// output logs and immediate-assertion checks against hand-computed values.
module tb_ft_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_rdata = 8'h00;
  logic        rx_rempty = 1'b1;
  logic        rx_rinc;
  logic [7:0]  tx_wdata;
  logic        tx_wfull = 1'b0;
  logic        tx_winc;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata = 16'hDEAD;
  logic [7:0]  err_count;
  logic [3:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  rx_buf [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  logic [15:0] rd_value = 16'hBEEF;
  logic        re_prev = 1'b0;

  logic [23:0] wr_log[$];
  int          wr_lat[$];
  int          re_lat[$];
  logic [7:0]  tx_log[$];
  int          tx_lat[$];

  ft_cmd_parser #(.SYNC_BYTE(8'hA5), .RESP_BYTE(8'h5A), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rx_rdata(rx_rdata), .rx_rempty(rx_rempty), .rx_rinc(rx_rinc),
    .tx_wdata(tx_wdata), .tx_wfull(tx_wfull), .tx_winc(tx_winc),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .err_count(err_count), .fsm_state(fsm_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- RX FIFO model: pop on accepting edge, refresh head 1ns after each edge ----
  always @(clk) begin
    if (clk === 1'b1 && rx_rinc === 1'b1 && rd_ptr != wr_ptr) begin
      rd_ptr = rd_ptr + 1;
      last_pop_cyc = cyc;
    end
    #1;
    rx_rempty = (rd_ptr == wr_ptr);
    rx_rdata  = (rd_ptr == wr_ptr) ? 8'h00 : rx_buf[rd_ptr % 4096];
  end

  // ---- monitor and register read responder (falling edge) ----
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reg_we === 1'b1) begin
      wr_log.push_back({reg_addr, reg_wdata});
      wr_lat.push_back(cyc - last_pop_cyc);
    end
    if (reg_re === 1'b1) re_lat.push_back(cyc - last_pop_cyc);
    if (tx_winc === 1'b1) begin
      tx_log.push_back(tx_wdata);
      tx_lat.push_back(cyc - last_pop_cyc);
    end
    reg_rdata = re_prev ? rd_value : 16'hDEAD;
    re_prev   = (reg_re === 1'b1);
  end

  // ---- driver tasks ----
  task automatic push_byte(input logic [7:0] b);
    rx_buf[wr_ptr % 4096] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_frame(input logic [7:0] b0, b1, b2, b3, b4);
    push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3); push_byte(b4);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (rd_ptr != wr_ptr && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(rd_ptr == wr_ptr), 32'd1);
  endtask

  // ---- watchdog ----
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- directed sequence ----
  initial begin
    int w0, t0, r0, held;

    // reset values
    wait_cycles(3);
    chk("rst_rx_rinc", 32'(rx_rinc), 32'd0);
    chk("rst_tx_winc", 32'(tx_winc), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_reg_re", 32'(reg_re), 32'd0);
    chk("rst_tx_wdata", 32'(tx_wdata), 32'h00);
    chk("rst_reg_addr", 32'(reg_addr), 32'h00);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'h0000);
    chk("rst_err_count", 32'(err_count), 32'h00);
    rst = 1'b0;
    wait_cycles(2);

    // 1: single write
    w0 = wr_log.size(); t0 = tx_log.size();
    push_frame(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34);
    wait_drain("t1", 50);
    wait_cycles(10);
    chk("t1_wr_count", 32'(wr_log.size() - w0), 32'd1);
    chk("t1_wr_data", 32'(wr_log[w0]), 32'h101234);
    chk("t1_wr_latency", 32'(wr_lat[w0]), 32'd1);
    chk("t1_no_tx", 32'(tx_log.size() - t0), 32'd0);
    chk("t1_addr_hold", 32'(reg_addr), 32'h10);
    chk("t1_wdata_hold", 32'(reg_wdata), 32'h1234);

    // 2: read with response
    w0 = wr_log.size(); t0 = tx_log.size(); r0 = re_lat.size();
    rd_value = 16'hBEEF;
    push_frame(8'hA5, 8'h02, 8'h22, 8'h00, 8'h00);
    wait_drain("t2", 50);
    wait_cycles(12);
    chk("t2_re_count", 32'(re_lat.size() - r0), 32'd1);
    chk("t2_re_latency", 32'(re_lat[r0]), 32'd1);
    chk("t2_tx_count", 32'(tx_log.size() - t0), 32'd4);
    chk("t2_tx_bytes", {tx_log[t0], tx_log[t0+1], tx_log[t0+2], tx_log[t0+3]}, 32'h5A22BEEF);
    chk("t2_tx_latency", 32'(tx_lat[t0]), 32'd3);
    chk("t2_no_write", 32'(wr_log.size() - w0), 32'd0);
    chk("t2_wdata_kept", 32'(reg_wdata), 32'h1234);

    // 3: TX FIFO full holds the response and blocks further RX pops
    w0 = wr_log.size(); t0 = tx_log.size();
    tx_wfull = 1'b1;
    push_frame(8'hA5, 8'h02, 8'h22, 8'h00, 8'h00);
    push_frame(8'hA5, 8'h01, 8'h44, 8'hAB, 8'hCD);
    begin
      int n = 0;
      while ((wr_ptr - rd_ptr) != 5 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    wait_cycles(20);
    held = wr_ptr - rd_ptr;
    chk("t3_rx_held", 32'(held), 32'd5);
    chk("t3_tx_held", 32'(tx_log.size() - t0), 32'd0);
    chk("t3_no_write", 32'(wr_log.size() - w0), 32'd0);
    tx_wfull = 1'b0;
    wait_drain("t3", 50);
    wait_cycles(10);
    chk("t3_tx_count", 32'(tx_log.size() - t0), 32'd4);
    chk("t3_tx_bytes", {tx_log[t0], tx_log[t0+1], tx_log[t0+2], tx_log[t0+3]}, 32'h5A22BEEF);
    chk("t3_wr_count", 32'(wr_log.size() - w0), 32'd1);
    chk("t3_wr_data", 32'(wr_log[w0]), 32'h44ABCD);

    // 4: garbage in HUNT, invalid command, then a good write
    w0 = wr_log.size(); r0 = re_lat.size();
    push_byte(8'h00); push_byte(8'hFF);
    push_frame(8'hA5, 8'h07, 8'h01, 8'h02, 8'h03);
    push_frame(8'hA5, 8'h01, 8'h01, 8'h00, 8'h05);
    wait_drain("t4", 60);
    wait_cycles(10);
    chk("t4_err_count", 32'(err_count), 32'd1);
    chk("t4_wr_count", 32'(wr_log.size() - w0), 32'd1);
    chk("t4_wr_data", 32'(wr_log[w0]), 32'h010005);
    chk("t4_no_read", 32'(re_lat.size() - r0), 32'd0);

    // 5: reset mid-frame discards the partial frame
    w0 = wr_log.size();
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h10);
    wait_drain("t5a", 30);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    chk("t5_rst_err", 32'(err_count), 32'd0);
    chk("t5_rst_addr", 32'(reg_addr), 32'h00);
    chk("t5_rst_wdata", 32'(reg_wdata), 32'h0000);
    rst = 1'b0;
    wait_cycles(1);
    push_frame(8'hA5, 8'h01, 8'h20, 8'h00, 8'h01);
    wait_drain("t5b", 50);
    wait_cycles(10);
    chk("t5_wr_count", 32'(wr_log.size() - w0), 32'd1);
    chk("t5_wr_data", 32'(wr_log[w0]), 32'h200001);

`ifdef CMD_TIMEOUT_EN
    // 6: partial frame dropped after 16 idle cycles
    w0 = wr_log.size();
    push_byte(8'hA5); push_byte(8'h01);
    wait_drain("t6a", 30);
    wait_cycles(14);
    chk("t6_err_before", 32'(err_count), 32'd0);
    wait_cycles(2);
    chk("t6_err_after", 32'(err_count), 32'd1);
    push_frame(8'hA5, 8'h01, 8'h30, 8'h00, 8'h02);
    wait_drain("t6b", 50);
    wait_cycles(10);
    chk("t6_wr_count", 32'(wr_log.size() - w0), 32'd1);
    chk("t6_wr_data", 32'(wr_log[w0]), 32'h300002);
    chk("t6_err_final", 32'(err_count), 32'd1);
`endif

    // 7: err_count saturates
    w0 = wr_log.size(); r0 = re_lat.size();
    for (int i = 0; i < 256; i++) push_frame(8'hA5, 8'h03, 8'h00, 8'h00, 8'h00);
    wait_drain("t7", 4000);
    wait_cycles(5);
    chk("t7_err_sat", 32'(err_count), 32'hFF);
    chk("t7_no_write", 32'(wr_log.size() - w0), 32'd0);
    chk("t7_no_read", 32'(re_lat.size() - r0), 32'd0);

    // 8: reset clears the saturated counter
    rst = 1'b1;
    wait_cycles(2);
    chk("t8_rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
